// File: rtl/jb_pkg.sv
// Shared types and timing helpers for the joybus console response transmitter.
package jb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURNAROUND,
        ST_BIT,
        ST_STOP_LOW,
        ST_STOP_HIGH,
        ST_DONE
    } tx_state_e;

    localparam int unsigned JB_CYC_PER_US_DEF = 25;

    // All widths are in clk cycles; every value must fit the 8-bit bit timer.
    function automatic logic [7:0] bit_period_cyc(input int unsigned cyc_per_us);
        return 8'(4 * cyc_per_us);
    endfunction

    function automatic logic [7:0] zero_low_cyc(input int unsigned cyc_per_us);
        return 8'(3 * cyc_per_us);
    endfunction

    function automatic logic [7:0] one_low_cyc(input int unsigned cyc_per_us);
        return 8'(cyc_per_us);
    endfunction

    function automatic logic [7:0] stop_low_cyc(input int unsigned cyc_per_us);
        return 8'(cyc_per_us);
    endfunction

    function automatic logic [7:0] stop_high_cyc(input int unsigned cyc_per_us);
        return 8'(2 * cyc_per_us);
    endfunction

endpackage

// File: rtl/jb_bit_timer.sv
// One joybus symbol: line pulled low for low_cyc cycles, then released until period_cyc ends.
// line_low is a flop so the pad enable has no combinational path from the inputs.
module jb_bit_timer
    import jb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] low_cyc,
    input  logic [7:0] period_cyc,
    output logic       line_low,
    output logic       low_last,
    output logic       period_end
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] low_width_q, low_width_d;
    logic [7:0] period_q, period_d;
    logic       active_q, active_d;
    logic       line_low_q, line_low_d;

    always_comb begin
        cnt_d       = cnt_q;
        low_width_d = low_width_q;
        period_d    = period_q;
        active_d    = active_q;
        line_low_d  = line_low_q;
        low_last    = active_q && (cnt_q == low_width_q - 8'd1);
        period_end  = active_q && (cnt_q == period_q - 8'd1);

        // A start in the final cycle of a period chains the next symbol with no gap.
        if (start) begin
            cnt_d       = 8'd0;
            low_width_d = low_cyc;
            period_d    = period_cyc;
            active_d    = 1'b1;
            line_low_d  = (low_cyc != 8'd0);
        end else if (active_q) begin
            if (period_end) begin
                cnt_d      = 8'd0;
                active_d   = 1'b0;
                line_low_d = 1'b0;
            end else begin
                cnt_d      = cnt_q + 8'd1;
                line_low_d = (cnt_q + 8'd1) < low_width_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 8'd0;
            low_width_q <= 8'd0;
            period_q    <= 8'd0;
            active_q    <= 1'b0;
            line_low_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            low_width_q <= low_width_d;
            period_q    <= period_d;
            active_q    <= active_d;
            line_low_q  <= line_low_d;
        end
    end

    assign line_low = line_low_q;

endmodule

// File: rtl/console_tx.sv
// Joybus controller response transmitter: on a console poll edge, sends ctrl_data MSB first plus stop bit.
//
// state         | meaning
// IDLE          | line released, waiting for a poll rising edge
// TURNAROUND    | line released for TURNAROUND_CYC cycles before the first bit
// BIT           | sending data bits from the shift register MSB
// STOP_LOW      | stop bit, line pulled low
// STOP_HIGH     | stop bit, line released
// DONE          | one-cycle frame completion
module console_tx
    import jb_pkg::*;
#(
    parameter int unsigned CYC_PER_US     = JB_CYC_PER_US_DEF,
    parameter int unsigned TURNAROUND_CYC = 50,
    parameter int unsigned RESP_BITS      = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 console_did_poll,
    input  logic [RESP_BITS-1:0] ctrl_data,
    output logic                 jb_tx_low,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [7:0] BIT_PERIOD  = bit_period_cyc(CYC_PER_US);
    localparam logic [7:0] ZERO_LOW    = zero_low_cyc(CYC_PER_US);
    localparam logic [7:0] ONE_LOW     = one_low_cyc(CYC_PER_US);
    localparam logic [7:0] STOP_LOW    = stop_low_cyc(CYC_PER_US);
    localparam logic [7:0] STOP_PERIOD = stop_low_cyc(CYC_PER_US) + stop_high_cyc(CYC_PER_US);
    localparam int unsigned TW         = (TURNAROUND_CYC > 1) ? $clog2(TURNAROUND_CYC) : 1;
    localparam logic [TW-1:0] TURN_LAST = TW'((TURNAROUND_CYC > 0) ? TURNAROUND_CYC - 1 : 0);
    localparam logic [6:0] LAST_BIT    = 7'(RESP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic                 poll_prev_q;
    logic [RESP_BITS-1:0] shift_q, shift_d, shift_shl;
    logic [6:0]           bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]        turn_q, turn_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 accept;
    logic                 tmr_start;
    logic [7:0]           tmr_low;
    logic [7:0]           tmr_period;
    logic                 tmr_low_last;
    logic                 tmr_period_end;

    function automatic logic [7:0] low_for(input logic b);
        return b ? ONE_LOW : ZERO_LOW;
    endfunction

    assign shift_shl = shift_q << 1;
    // tx_busy_q gates acceptance so an edge in the cycle after DONE is also dropped.
    assign accept = (state_q == ST_IDLE) && console_did_poll && !poll_prev_q && !tx_busy_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        turn_d     = turn_q;
        tmr_start  = 1'b0;
        tmr_low    = ONE_LOW;
        tmr_period = BIT_PERIOD;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d   = ctrl_data;
                    bit_cnt_d = 7'd0;
                    turn_d    = '0;
                    if (TURNAROUND_CYC == 0) begin
                        state_d   = ST_BIT;
                        tmr_start = 1'b1;
                        tmr_low   = low_for(ctrl_data[RESP_BITS-1]);
                    end else begin
                        state_d = ST_TURNAROUND;
                    end
                end
            end
            ST_TURNAROUND: begin
                turn_d = turn_q + 1'b1;
                if (turn_q == TURN_LAST) begin
                    state_d   = ST_BIT;
                    tmr_start = 1'b1;
                    tmr_low   = low_for(shift_q[RESP_BITS-1]);
                end
            end
            ST_BIT: begin
                if (tmr_period_end) begin
                    shift_d   = shift_shl;
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    tmr_start = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = ST_STOP_LOW;
                        tmr_low    = STOP_LOW;
                        tmr_period = STOP_PERIOD;
                    end else begin
                        tmr_low = low_for(shift_shl[RESP_BITS-1]);
                    end
                end
            end
            ST_STOP_LOW: begin
                if (tmr_low_last) state_d = ST_STOP_HIGH;
            end
            ST_STOP_HIGH: begin
                if (tmr_period_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_busy_d = (state_q != ST_IDLE) || accept;
        tx_done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            poll_prev_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= 7'd0;
            turn_q      <= '0;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            poll_prev_q <= console_did_poll;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            turn_q      <= turn_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

    jb_bit_timer u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (tmr_start),
        .low_cyc    (tmr_low),
        .period_cyc (tmr_period),
        .line_low   (jb_tx_low),
        .low_last   (tmr_low_last),
        .period_end (tmr_period_end)
    );

    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_console_tx.sv
// Bench for console_tx: default-parameter instance plus a short-frame instance (no turnaround, 8 bits).
module tb_console_tx;

    localparam int T_A = 50;
    localparam int B_A = 64;
    localparam int T_B = 0;
    localparam int B_B = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        poll_a = 1'b0;
    logic        poll_b = 1'b0;
    logic [63:0] data_a = '0;
    logic [7:0]  data_b = '0;
    logic        low_a, busy_a, done_a;
    logic        low_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;
    int widths_q[$];

    always #20 clk = ~clk;

    console_tx dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .console_did_poll (poll_a),
        .ctrl_data        (data_a),
        .jb_tx_low        (low_a),
        .tx_busy          (busy_a),
        .tx_done          (done_a)
    );

    console_tx #(.CYC_PER_US(25), .TURNAROUND_CYC(T_B), .RESP_BITS(B_B)) dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .console_did_poll (poll_b),
        .ctrl_data        (data_b),
        .jb_tx_low        (low_b),
        .tx_busy          (busy_b),
        .tx_done          (done_b)
    );

    typedef struct {
        int          sel;
        logic [63:0] data;
        int          inv_at;
        int          repoll_at;
        bit          hold;
        int          exp_len;
        int          exp_first;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: k cycles after acceptance; bit i occupies 100 cycles starting at 1+t+100*i.
    function automatic bit model_low(input int k, input logic [63:0] d, input int t, input int b);
        int off;
        int bit_i;
        int ph;
        off = k - 1 - t;
        if (off < 0) return 1'b0;
        if (off < 100 * b) begin
            bit_i = off / 100;
            ph    = off % 100;
            return ph < (d[b - 1 - bit_i] ? 25 : 75);
        end
        off = off - 100 * b;
        return off < 25;
    endfunction

    task automatic run_frame(input int sel, input logic [63:0] d, input int inv_at,
                             input int repoll_at, input bit hold, input bit rel_reset,
                             input int abort_at, input int exp_len, input int exp_first,
                             input string name);
        int t = sel ? T_B : T_A;
        int b = sel ? B_B : B_A;
        int len = t + 100 * b + 77;
        int win = len + t + 60;
        int wave_err = 0;
        int first_bad = -1;
        int first_low = -1;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at = -1;
        int run = 0;
        logic l, bz, dn;
        bit ml, mb, md;
        widths_q.delete();
        if (sel != 0) data_b = d[7:0]; else data_a = d;
        @(negedge clk);
        if (sel != 0) poll_b = 1'b1; else poll_a = 1'b1;
        if (rel_reset) rst_n = 1'b1;
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            l  = (sel != 0) ? low_b  : low_a;
            bz = (sel != 0) ? busy_b : busy_a;
            dn = (sel != 0) ? done_b : done_a;
            ml = model_low(k, d, t, b);
            mb = (k >= 1) && (k <= len);
            md = (k == len);
            if ({l, bz, dn} !== {ml, mb, md}) begin
                wave_err++;
                if (first_bad < 0) first_bad = k;
            end
            if (l === 1'b1) begin
                run++;
                if (first_low < 0) first_low = k;
            end else if (run > 0) begin
                widths_q.push_back(run);
                run = 0;
            end
            if (bz === 1'b1) busy_cnt++;
            if (dn === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k == abort_at) begin
                #5 rst_n = 1'b0;
                #1;
                check({name, " async line"}, (sel != 0) ? low_b : low_a, 0);
                check({name, " async busy"}, (sel != 0) ? busy_b : busy_a, 0);
                check({name, " async done"}, (sel != 0) ? done_b : done_a, 0);
                break;
            end
            if (k == inv_at) begin
                if (sel != 0) data_b = ~d[7:0]; else data_a = ~d;
            end
            if (k == repoll_at - 10) begin
                if (sel != 0) poll_b = 1'b0; else poll_a = 1'b0;
            end
            if (k == repoll_at) begin
                if (sel != 0) poll_b = 1'b1; else poll_a = 1'b1;
            end
            if (!hold && (k == 5 || k == repoll_at + 5)) begin
                if (sel != 0) poll_b = 1'b0; else poll_a = 1'b0;
            end
        end
        poll_a = 1'b0;
        poll_b = 1'b0;
        check($sformatf("%s waveform mismatch cycles (first bad k=%0d)", name, first_bad), wave_err, 0);
        if (abort_at == 0) begin
            check({name, " first low cycle"}, first_low, exp_first);
            check({name, " busy cycles"}, busy_cnt, exp_len);
            check({name, " done cycle"}, done_at, exp_len);
            check({name, " done pulses"}, done_cnt, 1);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vec_t vecs[5];
        int   exp_w[9];
        logic [63:0] rd;
        exp_w = '{25, 75, 25, 75, 75, 25, 75, 25, 25};
        vecs[0] = '{0, 64'h8000_0000_0000_0001, 0, 0, 1'b0, 6527, 51, "msb_lsb"};
        vecs[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b0, 6527, 51, "all_ones"};
        vecs[2] = '{0, 64'h0123_4567_89AB_CDEF, 200, 0, 1'b0, 6527, 51, "latch_inv"};
        vecs[3] = '{0, 64'hF0F0_1234_5555_AAAA, 0, 1000, 1'b1, 6527, 51, "repoll_hold"};
        vecs[4] = '{1, 64'h0000_0000_0000_00A5, 0, 0, 1'b0, 877, 1, "short_a5"};

        repeat (3) @(negedge clk);
        check("reset line a", low_a, 0);
        check("reset busy a", busy_a, 0);
        check("reset done a", done_a, 0);
        check("reset line b", low_b, 0);
        check("reset busy b", busy_b, 0);
        check("reset done b", done_b, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].sel, vecs[i].data, vecs[i].inv_at, vecs[i].repoll_at,
                      vecs[i].hold, 1'b0, 0, vecs[i].exp_len, vecs[i].exp_first, vecs[i].name);
        end

        check("short_a5 pulse count", widths_q.size(), 9);
        for (int i = 0; i < 9 && i < widths_q.size(); i++)
            check($sformatf("short_a5 pulse %0d width", i), widths_q[i], exp_w[i]);

        run_frame(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b0, 1'b0, 0, 6527, 51, "ones_pulses");
        check("ones pulse count", widths_q.size(), 65);
        for (int i = 0; i < widths_q.size(); i++)
            check($sformatf("ones pulse %0d width", i), widths_q[i], 25);

        run_frame(0, 64'h0, 0, 0, 1'b0, 1'b0, 3000, 6527, 51, "rst_abort");
        repeat (3) @(negedge clk);
        check("held reset busy", busy_a, 0);
        check("held reset line", low_a, 0);
        poll_a = 1'b1;
        run_frame(0, 64'hDEAD_BEEF_0F1E_2D3C, 0, 0, 1'b0, 1'b1, 0, 6527, 51, "post_reset");

        for (int i = 0; i < 4; i++) begin
            rd = {$urandom, $urandom};
            run_frame(1, rd, 300, 0, 1'b0, 1'b0, 0, 877, 1, $sformatf("rand_short_%0d", i));
        end
        rd = {$urandom, $urandom};
        run_frame(0, rd, 2500, 0, 1'b0, 1'b0, 0, 6527, 51, "rand_long");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
